// File: rtl/bus_slave_decoder.sv
// Single-master to N-slave bus decoder with per-slave wait states,
// slave-ready handshake with timeout, registered read mux and error capture.
module bus_slave_decoder #(
    parameter int unsigned ADDR_BUS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NR_SLAVES      = 4,
    parameter logic [NR_SLAVES*ADDR_BUS_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NR_SLAVES*ADDR_BUS_WIDTH-1:0] SLAVE_MASK = '0,
    parameter logic [NR_SLAVES*4-1:0]              SLAVE_WAIT = '0,
    parameter int unsigned TIMEOUT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_BUS_WIDTH-1:0]       m_addr,
    input  logic [DATA_WIDTH-1:0]           m_out,
    input  logic                            m_write_w,
    input  logic                            m_write_h,
    input  logic                            m_write_b,
    input  logic                            m_rd,
    output logic [DATA_WIDTH-1:0]           m_in,
    output logic                            m_ready,
    output logic                            m_err,
    output logic                            m_busy,
    output logic [ADDR_BUS_WIDTH-1:0]       err_addr,
    output logic [ADDR_BUS_WIDTH-1:0]       s_addr,
    output logic [DATA_WIDTH-1:0]           s_out,
    output logic [NR_SLAVES-1:0]            s_cs,
    output logic                            s_write_w,
    output logic                            s_write_h,
    output logic                            s_write_b,
    input  logic [NR_SLAVES*DATA_WIDTH-1:0] s_in,
    input  logic [NR_SLAVES-1:0]            s_ready
);

    localparam int unsigned SEL_W = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;
    localparam logic [TIMEOUT_WIDTH-1:0] TO_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
    typedef enum logic [1:0] {ACC_RD, ACC_WW, ACC_WH, ACC_WB} acc_t;

    state_t                     state_q, state_d;
    acc_t                       acc_q, acc_d;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic [3:0]                 wait_q, wait_d;
    logic [TIMEOUT_WIDTH-1:0]   to_q, to_d;
    logic [ADDR_BUS_WIDTH-1:0]  s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0]      s_out_q, s_out_d;
    logic [NR_SLAVES-1:0]       s_cs_q, s_cs_d;
    logic [DATA_WIDTH-1:0]      m_in_q, m_in_d;
    logic                       m_ready_q, m_ready_d;
    logic                       m_err_q, m_err_d;
    logic [ADDR_BUS_WIDTH-1:0]  err_addr_q, err_addr_d;

    logic [DATA_WIDTH-1:0]      s_in_arr [NR_SLAVES];
    logic [3:0]                 wait_arr [NR_SLAVES];
    logic                       req;
    acc_t                       req_acc;
    logic                       hit;
    logic [SEL_W-1:0]           hit_idx;
    logic                       slave_rdy;
    logic                       complete;
    logic                       abort;

    // Unpack per-slave read data and wait-state tables
    always_comb begin
        for (int i = 0; i < int'(NR_SLAVES); i++) begin
            s_in_arr[i] = s_in[i*DATA_WIDTH +: DATA_WIDTH];
            wait_arr[i] = SLAVE_WAIT[i*4 +: 4];
        end
    end

    // Request classification (writes beat reads, w > h > b) and address decode (lowest index wins)
    always_comb begin
        req     = m_rd | m_write_w | m_write_h | m_write_b;
        req_acc = ACC_RD;
        if (m_write_w)      req_acc = ACC_WW;
        else if (m_write_h) req_acc = ACC_WH;
        else if (m_write_b) req_acc = ACC_WB;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NR_SLAVES) - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH])
                    == SLAVE_BASE[i*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    // Access-phase completion / timeout conditions
    always_comb begin
        slave_rdy = s_ready[sel_q];
        complete  = (state_q == ST_ACCESS) && (wait_q == 4'd0) && slave_rdy;
        abort     = (state_q == ST_ACCESS) && (wait_q == 4'd0) && !slave_rdy && (to_q == TO_MAX);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= ACC_RD;
            sel_q      <= '0;
            wait_q     <= '0;
            to_q       <= '0;
            s_addr_q   <= '0;
            s_out_q    <= '0;
            s_cs_q     <= '0;
            m_in_q     <= '0;
            m_ready_q  <= 1'b0;
            m_err_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sel_q      <= sel_d;
            wait_q     <= wait_d;
            to_q       <= to_d;
            s_addr_q   <= s_addr_d;
            s_out_q    <= s_out_d;
            s_cs_q     <= s_cs_d;
            m_in_q     <= m_in_d;
            m_ready_q  <= m_ready_d;
            m_err_q    <= m_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) state_d = hit ? ST_ACCESS : ST_DONE;
            end
            ST_ACCESS: begin
                if (complete || abort) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath / registered-output next values
    always_comb begin
        acc_d      = acc_q;
        sel_d      = sel_q;
        wait_d     = wait_q;
        to_d       = to_q;
        s_addr_d   = s_addr_q;
        s_out_d    = s_out_q;
        s_cs_d     = s_cs_q;
        m_in_d     = m_in_q;
        m_ready_d  = 1'b0;
        m_err_d    = 1'b0;
        err_addr_d = err_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    acc_d    = req_acc;
                    s_addr_d = m_addr;
                    s_out_d  = m_out;
                    if (hit) begin
                        sel_d  = hit_idx;
                        s_cs_d = NR_SLAVES'(1) << hit_idx;
                        wait_d = wait_arr[hit_idx];
                        to_d   = '0;
                    end else begin
                        s_cs_d     = '0;
                        m_ready_d  = 1'b1;
                        m_err_d    = 1'b1;
                        m_in_d     = '0;
                        err_addr_d = m_addr;
                    end
                end
            end
            ST_ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (slave_rdy) begin
                    if (acc_q == ACC_RD) m_in_d = s_in_arr[sel_q];
                    m_ready_d = 1'b1;
                    s_cs_d    = '0;
                end else if (to_q == TO_MAX) begin
                    m_ready_d  = 1'b1;
                    m_err_d    = 1'b1;
                    m_in_d     = '0;
                    err_addr_d = s_addr_q;
                    s_cs_d     = '0;
                end else begin
                    to_d = to_q + TIMEOUT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    // Write strobes fire only in the completing access cycle
    always_comb begin
        s_write_w = complete && (acc_q == ACC_WW);
        s_write_h = complete && (acc_q == ACC_WH);
        s_write_b = complete && (acc_q == ACC_WB);
    end

    assign m_in     = m_in_q;
    assign m_ready  = m_ready_q;
    assign m_err    = m_err_q;
    assign m_busy   = (state_q != ST_IDLE);
    assign err_addr = err_addr_q;
    assign s_addr   = s_addr_q;
    assign s_out    = s_out_q;
    assign s_cs     = s_cs_q;

endmodule

// File: tb/tb_bus_slave_decoder.sv
// Self-checking bench for bus_slave_decoder: vector table plus timeout and reset sequences.
module tb_bus_slave_decoder;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned NS = 3;
    localparam int unsigned TW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_out;
    logic            m_write_w, m_write_h, m_write_b, m_rd;
    logic [DW-1:0]   m_in;
    logic            m_ready, m_err, m_busy;
    logic [AW-1:0]   err_addr, s_addr;
    logic [DW-1:0]   s_out;
    logic [NS-1:0]   s_cs;
    logic            s_write_w, s_write_h, s_write_b;
    logic [NS*DW-1:0] s_in;
    logic [NS-1:0]   s_ready;

    logic [DW-1:0]   sd [NS];

    always #5 clk = ~clk;

    assign s_in = {sd[2], sd[1], sd[0]};

    bus_slave_decoder #(
        .ADDR_BUS_WIDTH(AW),
        .DATA_WIDTH    (DW),
        .NR_SLAVES     (NS),
        .SLAVE_BASE    ({16'h2000, 16'h4000, 16'h8000}),
        .SLAVE_MASK    ({16'hE000, 16'hC000, 16'h8000}),
        .SLAVE_WAIT    ({4'd0, 4'd2, 4'd0}),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_addr   (m_addr),
        .m_out    (m_out),
        .m_write_w(m_write_w),
        .m_write_h(m_write_h),
        .m_write_b(m_write_b),
        .m_rd     (m_rd),
        .m_in     (m_in),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .m_busy   (m_busy),
        .err_addr (err_addr),
        .s_addr   (s_addr),
        .s_out    (s_out),
        .s_cs     (s_cs),
        .s_write_w(s_write_w),
        .s_write_h(s_write_h),
        .s_write_b(s_write_b),
        .s_in     (s_in),
        .s_ready  (s_ready)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rd, ww, wh, wb;
        logic [NS-1:0] cs;      // expected select while in ACCESS
        int            lat;     // expected m_ready cycle after the request edge
        logic          err;
        logic [2:0]    strobe;  // expected strobes {w,h,b}
    } vec_t;

    typedef struct {
        logic [DW-1:0] m_in;
        logic          err;
        logic [AW-1:0] err_addr;
    } sb_t;

    sb_t           sb_q [$];
    logic [DW-1:0] mdl_in;
    logic [AW-1:0] mdl_err_addr;
    int            n_tests = 0;
    int            n_fail  = 0;
    vec_t          vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every m_ready pops and checks one expected completion
    always @(negedge clk) begin : monitor
        sb_t e;
        if (rst && m_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: got m_ready=1 expected no completion");
            end else begin
                e = sb_q.pop_front();
                check("sb_m_in", 64'(m_in), 64'(e.m_in));
                check("sb_m_err", 64'(m_err), 64'(e.err));
                check("sb_err_addr", 64'(err_addr), 64'(e.err_addr));
            end
        end
    end

    task automatic run_access(input vec_t v, input string tag);
        int   n;
        int   lat;
        int   busy;
        int   cs_bad;
        int   cw, ch, cb;
        logic got;
        sb_t  e;
        @(negedge clk);
        m_addr    = v.addr;
        m_out     = v.wdata;
        m_rd      = v.rd;
        m_write_w = v.ww;
        m_write_h = v.wh;
        m_write_b = v.wb;
        if (v.err) begin
            mdl_in       = '0;
            mdl_err_addr = v.addr;
        end else if (!(v.ww | v.wh | v.wb)) begin
            mdl_in = v.cs[0] ? sd[0] : (v.cs[1] ? sd[1] : sd[2]);
        end
        e.m_in     = mdl_in;
        e.err      = v.err;
        e.err_addr = mdl_err_addr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        m_rd = 1'b0; m_write_w = 1'b0; m_write_h = 1'b0; m_write_b = 1'b0;
        got = 1'b0; lat = 0; busy = 0; cs_bad = 0; cw = 0; ch = 0; cb = 0; n = 0;
        while (!got && n < 400) begin
            n++;
            @(negedge clk);
            busy += int'(m_busy);
            cw   += int'(s_write_w);
            ch   += int'(s_write_h);
            cb   += int'(s_write_b);
            if (n == 1 && v.cs != '0) begin
                check({tag, "_s_addr"}, 64'(s_addr), 64'(v.addr));
                check({tag, "_s_out"}, 64'(s_out), 64'(v.wdata));
            end
            if (m_ready) begin
                got = 1'b1;
                lat = n;
                check({tag, "_cs_done"}, 64'(s_cs), 64'(0));
            end else if (s_cs !== v.cs) begin
                cs_bad++;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no m_ready within 400 cycles expected cycle %0d", tag, v.lat);
        end else begin
            check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        end
        check({tag, "_cs_hold_bad"}, 64'(cs_bad), 64'(0));
        check({tag, "_busy_cycles"}, 64'(busy), 64'(v.lat));
        check({tag, "_strobe_w"}, 64'(cw), 64'(v.strobe[2]));
        check({tag, "_strobe_h"}, 64'(ch), 64'(v.strobe[1]));
        check({tag, "_strobe_b"}, 64'(cb), 64'(v.strobe[0]));
        @(negedge clk);
        check({tag, "_idle_after"}, 64'(m_busy), 64'(0));
    endtask

    initial begin : stim
        int rdy_cnt;
        vec_t tv;
        sd[0] = 32'hDEADBEEF;
        sd[1] = 32'hCAFEF00D;
        sd[2] = 32'h12345678;
        s_ready = '1;
        rst = 1'b0;
        m_addr = '0; m_out = '0;
        m_rd = 1'b0; m_write_w = 1'b0; m_write_h = 1'b0; m_write_b = 1'b0;
        mdl_in = '0;
        mdl_err_addr = '0;

        //          addr      wdata         rd ww wh wb  cs      lat err strobe
        vecs[0]  = '{16'h8004, 32'h0,        1, 0, 0, 0, 3'b001, 2, 0, 3'b000};
        vecs[1]  = '{16'h4010, 32'h0,        1, 0, 0, 0, 3'b010, 4, 0, 3'b000};
        vecs[2]  = '{16'h2002, 32'h1234,     0, 0, 1, 0, 3'b100, 2, 0, 3'b010};
        vecs[3]  = '{16'h1000, 32'h0,        1, 0, 0, 0, 3'b000, 1, 1, 3'b000};
        vecs[4]  = '{16'h2FFC, 32'h0,        1, 0, 0, 0, 3'b100, 2, 0, 3'b000};
        vecs[5]  = '{16'hFFFF, 32'h0,        1, 0, 0, 0, 3'b001, 2, 0, 3'b000};
        vecs[6]  = '{16'h7000, 32'hA5A50001, 0, 1, 0, 0, 3'b010, 4, 0, 3'b100};
        vecs[7]  = '{16'h0000, 32'h0,        1, 0, 0, 0, 3'b000, 1, 1, 3'b000};
        vecs[8]  = '{16'h3000, 32'h000000FF, 1, 0, 0, 1, 3'b100, 2, 0, 3'b001};
        vecs[9]  = '{16'h8010, 32'h55AA55AA, 1, 1, 1, 0, 3'b001, 2, 0, 3'b100};
        vecs[10] = '{16'h5000, 32'h00000BEE, 0, 0, 1, 1, 3'b010, 4, 0, 3'b010};
        vecs[11] = '{16'h1FFF, 32'h0,        1, 0, 0, 0, 3'b000, 1, 1, 3'b000};
        vecs[12] = '{16'h0800, 32'h11111111, 0, 1, 0, 0, 3'b000, 1, 1, 3'b000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_in", 64'(m_in), 64'(0));
        check("rst_m_ready", 64'(m_ready), 64'(0));
        check("rst_m_err", 64'(m_err), 64'(0));
        check("rst_m_busy", 64'(m_busy), 64'(0));
        check("rst_err_addr", 64'(err_addr), 64'(0));
        check("rst_s_addr", 64'(s_addr), 64'(0));
        check("rst_s_out", 64'(s_out), 64'(0));
        check("rst_s_cs", 64'(s_cs), 64'(0));
        check("rst_strobes", 64'({s_write_w, s_write_h, s_write_b}), 64'(0));
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_access(vecs[i], $sformatf("vec%0d", i));
        end

        // Slave 0 never ready: read, then write+read both high, both time out
        s_ready = 3'b110;
        tv = '{16'h8000, 32'h0, 1, 0, 0, 0, 3'b001, 9, 1, 3'b000};
        run_access(tv, "to_read");
        tv = '{16'h8000, 32'hFFFF0000, 1, 1, 0, 0, 3'b001, 9, 1, 3'b000};
        run_access(tv, "to_write");
        s_ready = '1;

        // Reset in the middle of a WAIT=2 access drops it silently
        @(negedge clk);
        m_addr = 16'h4010;
        m_rd   = 1'b1;
        @(posedge clk);
        #1;
        m_rd = 1'b0;
        @(negedge clk);
        check("mid_cs_before_rst", 64'(s_cs), 64'(3'b010));
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_s_cs", 64'(s_cs), 64'(0));
        check("mid_rst_busy", 64'(m_busy), 64'(0));
        check("mid_rst_ready", 64'(m_ready), 64'(0));
        check("mid_rst_err_addr", 64'(err_addr), 64'(0));
        check("mid_rst_m_in", 64'(m_in), 64'(0));
        rst = 1'b1;
        mdl_in = '0;
        mdl_err_addr = '0;
        rdy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            rdy_cnt += int'(m_ready);
        end
        check("mid_rst_no_ready", 64'(rdy_cnt), 64'(0));
        tv = '{16'h4020, 32'h0, 1, 0, 0, 0, 3'b010, 4, 0, 3'b000};
        run_access(tv, "post_rst");

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_slave_decoder.md
Name: bus_slave_decoder

Overview:
- Parametrised single-master to N-slave bus decoder and read mux; the registered, wait-state-aware successor to the flat OR-style bus demux used by the single-bus SoC top.
- Sits between the core's pgm_* bus and N slaves (ROM, RAM, PIO, ...).
- Decodes address windows, sequences per-slave wait states and slave handshake, registers read data, and flags unmapped or timed-out accesses with an error and the faulting address.

Parameters:
- ADDR_BUS_WIDTH, 16: master/slave address width.
- DATA_WIDTH, 32: data bus width.
- NR_SLAVES, 4: number of slave ports, 1..16.
- SLAVE_BASE, 0: packed NR_SLAVES*ADDR_BUS_WIDTH; slot i is base of slave i.
- SLAVE_MASK, 0: packed NR_SLAVES*ADDR_BUS_WIDTH; slot i is compare mask of slave i.
- SLAVE_WAIT, 0: packed NR_SLAVES*4; fixed wait cycles per slave, 0..15.
- TIMEOUT_WIDTH, 8: width of the slave-ready timeout counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- m_addr  in  ADDR_BUS_WIDTH  master address.
- m_out  in  DATA_WIDTH  master write data.
- m_write_w / m_write_h / m_write_b  in  1 each  master word/half/byte write request.
- m_rd  in  1  master read request.
- m_in  out  DATA_WIDTH  registered read data to master.
- m_ready  out  1  one-cycle transaction-complete pulse.
- m_err  out  1  one-cycle error pulse, coincident with m_ready.
- m_busy  out  1  high while a transaction is outstanding.
- err_addr  out  ADDR_BUS_WIDTH  address of last erroring access (sticky).
- s_addr  out  ADDR_BUS_WIDTH  latched address to all slaves.
- s_out  out  DATA_WIDTH  latched write data to all slaves.
- s_cs  out  NR_SLAVES  one-hot slave select.
- s_write_w / s_write_h / s_write_b  out  1 each  write strobes to the selected slave.
- s_in  in  NR_SLAVES*DATA_WIDTH  packed slave read data; slot i belongs to slave i.
- s_ready  in  NR_SLAVES  per-slave ready; tie high if unused.

Behaviour:
- Reset (rst low at a clk edge):
  - state IDLE; all outputs 0, including err_addr, m_in and s_cs.
  - Wait and timeout counters cleared.
  - Any outstanding transaction is dropped with no m_ready.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - A request is any of m_rd, m_write_w, m_write_h, m_write_b sampled high.
  - Write beats read: if a write and m_rd are both high, the access is a write and m_rd is ignored.
  - Write priority w > h > b; only the winning strobe is latched.
  - Latched per request: m_addr, m_out, access type.
  - Decode: slave i hits when (m_addr & MASK_i) == BASE_i. Lowest hitting index wins.
  - Hit -> ACCESS, with s_cs[i]=1, wait_cnt=SLAVE_WAIT[i], to_cnt=0.
  - Miss -> DONE with error flagged; no s_cs asserted.
- ACCESS:
  - s_cs, s_addr and s_out are held stable.
  - If wait_cnt != 0: decrement.
  - Else if s_ready[i]=1: complete. The write strobe (if a write) is asserted this cycle only. Next state DONE.
  - Else: to_cnt increments. At to_cnt == 2^TIMEOUT_WIDTH-1, abort: no strobe, error flagged, next state DONE.
- Registered on the transition into DONE:
  - Read completion: m_in <= s_in[i].
  - Write completion: m_in holds its previous value.
  - Error: m_in <= 0 and err_addr <= latched address.
  - s_cs cleared on entering DONE.
- DONE:
  - m_ready=1 for exactly one cycle; m_err=1 in the same cycle if the access errored.
  - Next state IDLE.
- m_busy = (state != IDLE).
- Request sampling:
  - Requests are sampled only in IDLE; master inputs during ACCESS/DONE are ignored.
  - The master must deassert the request in the m_ready cycle unless it wants another access.
  - Earliest next request acceptance is the cycle after m_ready.
- Latency from the request edge:
  - hit with W waits and s_ready already high: m_ready at cycle 2+W;
  - unmapped: m_ready+m_err at cycle 1;
  - timeout: m_ready+m_err at cycle 2+W+(2^TIMEOUT_WIDTH-1).
- err_addr updates only on an error; it is not cleared by successful accesses.
- Arithmetic: wait_cnt is 4 bits, to_cnt is TIMEOUT_WIDTH bits; neither wraps (to_cnt stops at the abort value).

Test Plan:
- NR_SLAVES=3, BASE {0x8000,0x4000,0x2000}, MASK {0x8000,0xC000,0xE000}, WAIT {0,2,0}. Read 0x8004, slave0 s_in=0xDEADBEEF -> s_cs=3'b001 in cycle 1; m_in=0xDEADBEEF with m_ready in cycle 2; m_err=0.
- Read 0x4010 with slave1 WAIT=2 -> s_cs=3'b010 in cycles 1-3; m_ready in cycle 4; m_busy high in cycles 1-4.
- m_write_h with m_out=0x1234 to 0x2002 -> s_write_h high in exactly one cycle (cycle 1), s_out=0x1234, s_write_w=s_write_b=0; m_ready in cycle 2; m_in unchanged.
- Read unmapped 0x1000 -> no s_cs; m_ready=m_err=1 in cycle 1; m_in=0; err_addr=0x1000. Then a good read leaves err_addr at 0x1000.
- TIMEOUT_WIDTH=3, s_ready[0] held low, read 0x8000 -> m_err+m_ready at cycle 9; s_cs drops; no write strobe. Repeat with m_write_w and m_rd both high -> the access is a write, same timeout, no strobe issued.
- rst low during ACCESS of a WAIT=2 read -> next edge: s_cs=0, m_busy=0, m_ready never pulses; a fresh read after reset completes normally.
